// File: rtl/conv2d_maxpool_stream.sv
// 2x2 / stride-2 max pooling over a raster-order pixel stream, all channels in
// parallel. Even rows fold pairs into a half-row line buffer; odd rows finish each window.
module conv2d_maxpool_stream #(
  parameter  int bitWidth    = 17,
  parameter  int inputWidth  = 8,
  parameter  int numChannels = 2,
  localparam int PW = (inputWidth > 2) ? $clog2(inputWidth / 2) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic signed [numChannels-1:0][bitWidth-1:0] in_pixel,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic signed [numChannels-1:0][bitWidth-1:0] out_pixel,
  output logic [PW-1:0]                            out_row,
  output logic [PW-1:0]                            out_col,
  output logic                                     frame_done
);
  localparam int CW = PW + 1;
  localparam int HW = inputWidth / 2;
  localparam logic [CW-1:0] LAST = CW'(inputWidth - 1);

  typedef logic [numChannels-1:0][bitWidth-1:0] vec_t;

  logic [CW-1:0] row, col;
  logic [PW-1:0] lb_idx;
  vec_t          hold, lb_rd, max_hold, max_lb;
  vec_t          linebuf [HW];
  logic          accept, xfer, win_done;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign win_done = accept && row[0] && col[0];
  assign lb_idx   = col[CW-1:1];
  assign lb_rd    = linebuf[lb_idx];

  // Per-channel signed max of the incoming sample against hold and line buffer.
  for (genvar c = 0; c < numChannels; c++) begin : g_lane
    assign max_hold[c] = ($signed(hold[c])  > $signed(in_pixel[c])) ? hold[c]  : in_pixel[c];
    assign max_lb[c]   = ($signed(lb_rd[c]) > $signed(in_pixel[c])) ? lb_rd[c] : in_pixel[c];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row  <= '0;
      col  <= '0;
      hold <= '0;
    end else if (accept) begin
      if (col == LAST) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
      if (!col[0]) hold <= row[0] ? max_lb : vec_t'(in_pixel);
    end
  end

  // Not reset: every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (accept && !row[0] && col[0]) linebuf[lb_idx] <= max_hold;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else if (win_done) begin
      out_valid  <= 1'b1;
      out_pixel  <= max_hold;
      out_row    <= row[CW-1:1];
      out_col    <= lb_idx;
      frame_done <= (row == LAST) && (col == LAST);
    end else if (xfer) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv2d_maxpool_stream.sv
// Bench for conv2d_maxpool_stream: random-timed streams scored against a
// window-max model computed directly from the frame contents.
module tb_conv2d_maxpool_stream;
  localparam int BW = 17, IW = 8, NC = 2, PW = 2;
  localparam int NPF = IW * IW, NOF = (IW / 2) * (IW / 2);

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, frame_done;
  logic signed [NC-1:0][BW-1:0] in_pixel, out_pixel;
  logic [PW-1:0] out_row, out_col;

  int n_checks = 0, n_fail = 0;
  int m0[$], m1[$];
  logic signed [NC-1:0][BW-1:0] pix_q[$];
  int c0[$], c1[$], crow[$], ccol[$], cfd[$];
  int s_rdy[$], s_pix[$];
  bit timed_out;

  always #5 clk = ~clk;

  conv2d_maxpool_stream #(.bitWidth(BW), .inputWidth(IW), .numChannels(NC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done));

  // Expected pooled value j of the stream: max of the 2x2 window in its frame.
  function automatic int exp_max(input int ch, input int j);
    int f, w, pr, pc, k, v, best;
    f = j / NOF; w = j % NOF; pr = w / (IW / 2); pc = w % (IW / 2);
    best = -(1 << 30);
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        k = f * NPF + (2 * pr + dr) * IW + 2 * pc + dc;
        v = (ch == 0) ? m0[k] : m1[k];
        if (v > best) best = v;
      end
    return best;
  endfunction

  task automatic add_px(input int v0, input int v1);
    logic signed [NC-1:0][BW-1:0] p;
    p[0] = BW'(v0);
    p[1] = BW'(v1);
    m0.push_back(v0); m1.push_back(v1); pix_q.push_back(p);
  endtask

  task automatic clear_all();
    m0.delete(); m1.delete(); pix_q.delete();
    c0.delete(); c1.delete(); crow.delete(); ccol.delete(); cfd.delete();
    s_rdy.delete(); s_pix.delete();
  endtask

  task automatic build_ramp(input int off, input bit neg1, input int npix);
    for (int k = 0; k < npix; k++) add_px(k + off, neg1 ? -k : k + off);
  endtask

  // Drives pix_q with random gaps / output readiness and captures every transfer.
  task automatic stream(input int gap_pct, input int ready_pct, input int stall_len);
    int idx, stall_left, cyc;
    bit stalled;
    idx = 0; stall_left = 0; cyc = 0; stalled = 0; timed_out = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 4000) begin timed_out = 1; break; end
      if (stall_len > 0 && !stalled && out_valid) begin stalled = 1; stall_left = stall_len; end
      out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < ready_pct);
      if (idx < pix_q.size() && $urandom_range(99) >= gap_pct) begin
        in_valid = 1'b1; in_pixel = pix_q[idx];
      end else begin
        in_valid = 1'b0; in_pixel = '0;
      end
      #1;
      if (idx >= pix_q.size() && !out_valid) break;
      if (stall_left > 0) begin
        s_rdy.push_back(int'(in_ready));
        s_pix.push_back(int'($signed(out_pixel[0])));
        stall_left--;
      end
      if (out_valid && out_ready) begin
        c0.push_back(int'($signed(out_pixel[0])));
        c1.push_back(int'($signed(out_pixel[1])));
        crow.push_back(int'(out_row)); ccol.push_back(int'(out_col));
        cfd.push_back(int'(frame_done));
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got v=%b fd=%b exp 0/0", out_valid, frame_done);
    end
    n_checks++;
    if (out_pixel !== '0 || out_row !== '0 || out_col !== '0) begin
      n_fail++; $display("FAIL reset_data got pix=%h r=%0d c=%0d exp 0", out_pixel, out_row, out_col);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_ramp();
    clear_all(); build_ramp(0, 0, NPF); stream(0, 100, 0);
    n_checks++;
    if (timed_out || c0.size() != NOF) begin
      n_fail++; $display("FAIL ramp_count got %0d exp %0d (timeout=%0d)", c0.size(), NOF, timed_out);
    end
    foreach (c0[j]) begin
      n_checks++;
      if (c0[j] !== exp_max(0, j) || c1[j] !== exp_max(1, j)) begin
        n_fail++; $display("FAIL ramp_pix[%0d] got %0d/%0d exp %0d/%0d", j, c0[j], c1[j], exp_max(0, j), exp_max(1, j));
      end
      n_checks++;
      if (crow[j] !== (j % NOF) / 4 || ccol[j] !== j % 4 || cfd[j] !== int'(j % NOF == NOF - 1)) begin
        n_fail++; $display("FAIL ramp_pos[%0d] got r=%0d c=%0d fd=%0d", j, crow[j], ccol[j], cfd[j]);
      end
    end
  endtask

  task automatic test_signed();
    clear_all(); build_ramp(0, 1, NPF); stream(0, 100, 0);
    n_checks++;
    if (timed_out || c0.size() != NOF) begin
      n_fail++; $display("FAIL signed_count got %0d exp %0d", c0.size(), NOF);
    end
    foreach (c0[j]) begin
      n_checks++;
      if (c0[j] !== exp_max(0, j) || c1[j] !== exp_max(1, j)) begin
        n_fail++; $display("FAIL signed_pix[%0d] got %0d/%0d exp %0d/%0d", j, c0[j], c1[j], exp_max(0, j), exp_max(1, j));
      end
    end
  endtask

  task automatic test_backpressure();
    clear_all(); build_ramp(0, 0, NPF); stream(0, 100, 5);
    n_checks++;
    if (s_rdy.size() != 5) begin n_fail++; $display("FAIL bp_stall_len got %0d exp 5", s_rdy.size()); end
    foreach (s_rdy[i]) begin
      n_checks++;
      if (s_rdy[i] !== 0 || s_pix[i] !== 9) begin
        n_fail++; $display("FAIL bp_stall[%0d] got rdy=%0d pix=%0d exp 0/9", i, s_rdy[i], s_pix[i]);
      end
    end
    n_checks++;
    if (timed_out || c0.size() != NOF) begin n_fail++; $display("FAIL bp_count got %0d exp %0d", c0.size(), NOF); end
    foreach (c0[j]) begin
      n_checks++;
      if (c0[j] !== exp_max(0, j) || crow[j] !== j / 4 || ccol[j] !== j % 4) begin
        n_fail++; $display("FAIL bp_out[%0d] got %0d r=%0d c=%0d exp %0d", j, c0[j], crow[j], ccol[j], exp_max(0, j));
      end
    end
  endtask

  task automatic test_gaps();
    clear_all(); build_ramp(0, 0, NPF); stream(50, 100, 0);
    n_checks++;
    if (timed_out || c0.size() != NOF) begin n_fail++; $display("FAIL gaps_count got %0d exp %0d", c0.size(), NOF); end
    foreach (c0[j]) begin
      n_checks++;
      if (c0[j] !== exp_max(0, j) || c1[j] !== exp_max(1, j) || cfd[j] !== int'(j == NOF - 1)) begin
        n_fail++; $display("FAIL gaps_out[%0d] got %0d/%0d fd=%0d exp %0d", j, c0[j], c1[j], cfd[j], exp_max(0, j));
      end
    end
  endtask

  task automatic test_back_to_back();
    int nfd;
    clear_all(); build_ramp(0, 0, NPF); build_ramp(100, 0, NPF); stream(0, 100, 0);
    nfd = 0;
    n_checks++;
    if (timed_out || c0.size() != 2 * NOF) begin n_fail++; $display("FAIL b2b_count got %0d exp %0d", c0.size(), 2 * NOF); end
    foreach (c0[j]) begin
      nfd += cfd[j];
      n_checks++;
      if (c0[j] !== exp_max(0, j) || c1[j] !== exp_max(1, j) || crow[j] !== (j % NOF) / 4 || ccol[j] !== j % 4) begin
        n_fail++; $display("FAIL b2b_out[%0d] got %0d r=%0d c=%0d exp %0d", j, c0[j], crow[j], ccol[j], exp_max(0, j));
      end
    end
    n_checks++;
    if (nfd != 2) begin n_fail++; $display("FAIL b2b_frame_done got %0d exp 2", nfd); end
  endtask

  task automatic test_reset_midframe();
    clear_all(); build_ramp(0, 0, 21); stream(0, 100, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_pixel !== '0 || out_row !== '0 || out_col !== '0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_async got v=%b pix=%h r=%0d c=%0d exp all 0", out_valid, out_pixel, out_row, out_col);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_all(); build_ramp(0, 0, NPF); stream(20, 100, 0);
    n_checks++;
    if (timed_out || c0.size() != NOF) begin n_fail++; $display("FAIL midreset_count got %0d exp %0d", c0.size(), NOF); end
    foreach (c0[j]) begin
      n_checks++;
      if (c0[j] !== exp_max(0, j) || crow[j] !== j / 4 || ccol[j] !== j % 4 || cfd[j] !== int'(j == NOF - 1)) begin
        n_fail++; $display("FAIL midreset_out[%0d] got %0d r=%0d c=%0d exp %0d", j, c0[j], crow[j], ccol[j], exp_max(0, j));
      end
    end
  endtask

  task automatic test_random();
    clear_all();
    for (int k = 0; k < 2 * NPF; k++)
      add_px(int'($urandom_range(131071)) - 65536, int'($urandom_range(131071)) - 65536);
    stream(30, 60, 0);
    n_checks++;
    if (timed_out || c0.size() != 2 * NOF) begin n_fail++; $display("FAIL rand_count got %0d exp %0d", c0.size(), 2 * NOF); end
    foreach (c0[j]) begin
      n_checks++;
      if (c0[j] !== exp_max(0, j) || c1[j] !== exp_max(1, j) || cfd[j] !== int'(j % NOF == NOF - 1)) begin
        n_fail++; $display("FAIL rand_out[%0d] got %0d/%0d fd=%0d exp %0d/%0d", j, c0[j], c1[j], cfd[j], exp_max(0, j), exp_max(1, j));
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_signed();
    test_backpressure();
    test_gaps();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
